instr_mem_ctrl: RTL and testbench

Parametrised instruction memory with a valid/ready request/response interface and configurable read latency. It replaces the combinational PC-to-instruction lookup in the processor front end. It adds three things the older block lacks: alignment and range fault detection, a boot-time load port for writing program words, and backpressure from the fetch stage.

---
 rtl/instr_mem_pkg.sv | 24 ++
 rtl/instr_mem_array.sv | 55 +++++
 rtl/instr_mem_ctrl.sv | 132 +++++++++++++
 tb/tb_instr_mem_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and address helpers for the instruction memory controller.
// PCs are widened to 64 bits so the helpers serve any ADDR_WIDTH up to 64.
package instr_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef logic [63:0] pc_wide_t;

   function automatic pc_wide_t addr_to_index(input pc_wide_t pc);
      return pc >> 2;
   endfunction

   // Fault on a non-word-aligned PC or a word index past the end of the array.
   function automatic logic is_fault(input pc_wide_t pc, input int unsigned depth);
      return (pc[1:0] != 2'b00) || (addr_to_index(pc) >= pc_wide_t'(depth));
   endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Synchronous instruction RAM: one write port, one registered read port.
// A read and a write to the same word at the same edge return the old word.
module instr_mem_array #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned DATA_WIDTH  = 32,
   localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
   logic                  w_ok, r_ok;

   generate
      if ((1 << AW) == DEPTH_WORDS) begin : g_pow2
         assign w_ok = 1'b1;
         assign r_ok = 1'b1;
      end else begin : g_partial
         assign w_ok = (32'(waddr) < DEPTH_WORDS);
         assign r_ok = (32'(raddr) < DEPTH_WORDS);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (we && w_ok) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re && r_ok) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: valid/ready fetch port with fixed read latency,
// fault detection, and a boot-time load port into the backing RAM.
module instr_mem_ctrl
   import instr_mem_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH  = 32,
   parameter int unsigned            DATA_WIDTH  = 32,
   parameter int unsigned            DEPTH_WORDS = 256,
   parameter int unsigned            LATENCY     = 2,
   parameter logic [DATA_WIDTH-1:0]  NOP_INSTR   = DATA_WIDTH'(NOP_INSTR_DEFAULT),
   localparam int unsigned           MEM_AW      = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_pc,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_instr,
   output logic                  resp_fault,
   input  logic                  load_en,
   input  logic [MEM_AW-1:0]     load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  busy
);

   localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

   state_e                state_d, state_q;
   logic [3:0]            cnt_d, cnt_q;
   logic [MEM_AW-1:0]     idx_d, idx_q;
   logic                  pend_fault_d, pend_fault_q;
   logic                  resp_fault_d, resp_fault_q;
   logic                  rd_en;
   logic [MEM_AW-1:0]     rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  accept;
   pc_wide_t              pc_wide;
   logic [MEM_AW-1:0]     req_idx;
   logic                  req_fault;

   assign pc_wide   = pc_wide_t'(req_pc);
   assign req_idx   = MEM_AW'(addr_to_index(pc_wide));
   assign req_fault = is_fault(pc_wide, DEPTH_WORDS);

   assign req_ready = ~rst & ~load_en &
                      ((state_q == IDLE) | ((state_q == RESP) & resp_ready));
   assign accept    = req_valid & req_ready;

   // Only the in-range part of the index is kept; out-of-range requests are
   // already marked faulted and never touch the RAM.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      pend_fault_d = pend_fault_q;
      resp_fault_d = resp_fault_q;
      rd_en        = 1'b0;
      rd_addr      = idx_q;

      case (state_q)
         WAIT: begin
            if (cnt_q == '0) begin
               state_d      = RESP;
               rd_en        = ~pend_fault_q;
               resp_fault_d = pend_fault_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: ;
      endcase

      // With single-cycle latency the accept edge is also the RESP-entry edge,
      // so the RAM is addressed straight from the request.
      if (accept) begin
         if (LATENCY == 1) begin
            state_d      = RESP;
            rd_en        = ~req_fault;
            rd_addr      = req_idx;
            resp_fault_d = req_fault;
         end else begin
            state_d      = WAIT;
            cnt_d        = CNT_INIT;
            idx_d        = req_idx;
            pend_fault_d = req_fault;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_fault_q <= 1'b0;
         resp_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_fault_q <= pend_fault_d;
         resp_fault_q <= resp_fault_d;
      end
   end

   instr_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .DATA_WIDTH  (DATA_WIDTH)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (load_en),
      .waddr (load_addr),
      .wdata (load_data),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign resp_fault = resp_fault_q;
   assign resp_instr = resp_fault_q ? NOP_INSTR : rd_data;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: two instances (latency 2 and 4) share stimulus and are
// checked every cycle against a timestamp-based transaction model.
module tb_instr_mem_ctrl;

   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, req_valid, resp_ready, load_en;
   logic [31:0] req_pc, load_data;
   logic [7:0]  load_addr;

   logic        req_ready_o  [2];
   logic        resp_valid_o [2];
   logic        resp_fault_o [2];
   logic        busy_o       [2];
   logic [31:0] resp_instr_o [2];

   always #5 clk = ~clk;

   instr_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_l2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[0]), .req_pc(req_pc),
      .resp_valid(resp_valid_o[0]), .resp_ready(resp_ready), .resp_instr(resp_instr_o[0]),
      .resp_fault(resp_fault_o[0]), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .busy(busy_o[0]));

   instr_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(4)) u_dut_l4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[1]), .req_pc(req_pc),
      .resp_valid(resp_valid_o[1]), .resp_ready(resp_ready), .resp_instr(resp_instr_o[1]),
      .resp_fault(resp_fault_o[1]), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .busy(busy_o[1]));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Transaction model: a pending fetch resolves at edge (accept edge + latency - 1).
   int unsigned lat [2] = '{2, 4};
   logic [31:0] m_mem    [2][DEPTH];
   bit          m_pend   [2];
   int unsigned m_due    [2];
   logic [31:0] m_pidx   [2];
   bit          m_pfault [2];
   bit          m_rv     [2];
   logic [31:0] m_instr  [2];
   bit          m_fault  [2];
   int unsigned cyc = 0;

   function automatic bit m_ready(input int d);
      return !rst && !load_en && !m_pend[d] && (!m_rv[d] || resp_ready);
   endfunction

   function automatic void m_resolve(input int d);
      m_rv[d]    = 1'b1;
      m_fault[d] = m_pfault[d];
      if (m_pfault[d]) m_instr[d] = NOP;
      else             m_instr[d] = m_mem[d][m_pidx[d]];
      m_pend[d]  = 1'b0;
   endfunction

   function automatic void m_edge(input int d, input bit acc);
      if (rst) begin
         m_pend[d] = 1'b0; m_rv[d] = 1'b0; m_instr[d] = '0; m_fault[d] = 1'b0;
      end else begin
         if (m_pend[d] && cyc == m_due[d]) m_resolve(d);
         else if (m_rv[d] && resp_ready)   m_rv[d] = 1'b0;
         if (acc) begin
            m_pend[d]   = 1'b1;
            m_pidx[d]   = req_pc >> 2;
            m_pfault[d] = (req_pc[1:0] != 2'b00) || ((req_pc >> 2) >= DEPTH);
            m_due[d]    = cyc + lat[d] - 1;
            if (lat[d] == 1) m_resolve(d);
         end
      end
      if (load_en && (32'(load_addr) < DEPTH)) m_mem[d][load_addr] = load_data;
   endfunction

   task automatic tick();
      bit acc [2];
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("req_ready[%0d]", d), 32'(req_ready_o[d]), 32'(m_ready(d)));
         acc[d] = req_valid && m_ready(d);
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) m_edge(d, acc[d]);
      cyc++;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("resp_valid[%0d]", d), 32'(resp_valid_o[d]), 32'(m_rv[d]));
         chk($sformatf("busy[%0d]", d),       32'(busy_o[d]),       32'(m_rv[d] || m_pend[d]));
         chk($sformatf("resp_instr[%0d]", d), resp_instr_o[d],      m_instr[d]);
         chk($sformatf("resp_fault[%0d]", d), 32'(resp_fault_o[d]), 32'(m_fault[d]));
      end
      @(negedge clk);
   endtask

   task automatic set_idle();
      rst = 1'b0; req_valid = 1'b0; req_pc = '0; resp_ready = 1'b1;
      load_en = 1'b0; load_addr = '0; load_data = '0;
   endtask

   task automatic drain();
      int n = 0;
      set_idle();
      while ((m_pend[0] || m_rv[0] || m_pend[1] || m_rv[1]) && n < 30) begin
         tick();
         n++;
      end
      chk("drain_bound", 32'(n < 30), 32'd1);
   endtask

   typedef struct {
      bit          rv;
      logic [31:0] pc;
      bit          rr;
      bit          ld;
      logic [7:0]  la;
      logic [31:0] ldd;
      bit          exp_ready;
      bit          exp_rv;
      logic [31:0] exp_instr;
      bit          exp_fault;
   } vec_t;

   vec_t tbl [13];

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Latency-2 expectations: each row's outputs are those after its edge.
      tbl[0]  = '{0, 32'h0,   1, 1, 8'd0, 32'h0050_0093, 0, 0, 32'h0,         0};
      tbl[1]  = '{0, 32'h0,   1, 1, 8'd1, 32'h00A0_0113, 0, 0, 32'h0,         0};
      tbl[2]  = '{1, 32'h0,   1, 0, 8'd0, 32'h0,         1, 0, 32'h0,         0};
      tbl[3]  = '{0, 32'h0,   1, 0, 8'd0, 32'h0,         0, 1, 32'h0050_0093, 0};
      tbl[4]  = '{1, 32'h0,   1, 0, 8'd0, 32'h0,         1, 0, 32'h0050_0093, 0};
      tbl[5]  = '{1, 32'h4,   1, 0, 8'd0, 32'h0,         0, 1, 32'h0050_0093, 0};
      tbl[6]  = '{1, 32'h4,   1, 0, 8'd0, 32'h0,         1, 0, 32'h0050_0093, 0};
      tbl[7]  = '{1, 32'h6,   1, 0, 8'd0, 32'h0,         0, 1, 32'h00A0_0113, 0};
      tbl[8]  = '{1, 32'h6,   1, 0, 8'd0, 32'h0,         1, 0, 32'h00A0_0113, 0};
      tbl[9]  = '{1, 32'h400, 1, 0, 8'd0, 32'h0,         0, 1, NOP,           1};
      tbl[10] = '{1, 32'h400, 1, 0, 8'd0, 32'h0,         1, 0, NOP,           1};
      tbl[11] = '{0, 32'h0,   1, 0, 8'd0, 32'h0,         0, 1, NOP,           1};
      tbl[12] = '{0, 32'h0,   1, 0, 8'd0, 32'h0,         1, 0, NOP,           1};

      set_idle();
      rst = 1'b1;
      @(negedge clk);
      tick();
      tick();
      chk("reset_resp_valid", 32'(resp_valid_o[0]), 32'd0);
      chk("reset_resp_instr", resp_instr_o[0],      32'd0);
      chk("reset_resp_fault", 32'(resp_fault_o[0]), 32'd0);
      chk("reset_busy",       32'(busy_o[0]),       32'd0);
      rst = 1'b0;
      #1;
      chk("reset_release_ready", 32'(req_ready_o[0]), 32'd1);

      // Fill the whole array so every model read is defined.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         set_idle();
         load_en = 1'b1; load_addr = 8'(i); load_data = $urandom();
         tick();
      end
      set_idle();

      // Basic fetch, back-to-back, misaligned and out-of-range faults.
      for (int i = 0; i < 13; i++) begin
         req_valid = tbl[i].rv; req_pc = tbl[i].pc; resp_ready = tbl[i].rr;
         load_en = tbl[i].ld; load_addr = tbl[i].la; load_data = tbl[i].ldd;
         #1;
         chk($sformatf("tbl%0d_ready", i), 32'(req_ready_o[0]), 32'(tbl[i].exp_ready));
         tick();
         chk($sformatf("tbl%0d_valid", i), 32'(resp_valid_o[0]), 32'(tbl[i].exp_rv));
         chk($sformatf("tbl%0d_instr", i), resp_instr_o[0],      tbl[i].exp_instr);
         chk($sformatf("tbl%0d_fault", i), 32'(resp_fault_o[0]), 32'(tbl[i].exp_fault));
      end
      drain();

      // Backpressure in RESP, then handshake together with a new accept.
      req_valid = 1'b1; req_pc = 32'h4; resp_ready = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         req_pc = 32'h0;
         #1;
         chk("bp_ready", 32'(req_ready_o[0]), 32'd0);
         tick();
         chk("bp_valid", 32'(resp_valid_o[0]), 32'd1);
         chk("bp_instr", resp_instr_o[0],      32'h00A0_0113);
      end
      resp_ready = 1'b1;
      tick();
      chk("bp_reaccept_valid", 32'(resp_valid_o[0]), 32'd0);
      chk("bp_reaccept_busy",  32'(busy_o[0]),       32'd1);
      drain();

      // Load blocks accept; load timing relative to the read edge.
      req_valid = 1'b1; req_pc = 32'h8; load_en = 1'b1; load_addr = 8'd5; load_data = $urandom();
      #1;
      chk("load_blocks_ready", 32'(req_ready_o[0]), 32'd0);
      tick();
      chk("load_blocks_busy", 32'(busy_o[0]), 32'd0);
      set_idle();
      req_valid = 1'b1; req_pc = 32'h0;
      tick();
      set_idle();
      load_en = 1'b1; load_addr = 8'd0; load_data = 32'hDEAD_BEEF;
      tick();
      chk("load_same_edge_old", resp_instr_o[0], 32'h0050_0093);
      set_idle();
      tick();
      tick();
      chk("load_in_wait_valid", 32'(resp_valid_o[1]), 32'd1);
      chk("load_in_wait_new",   resp_instr_o[1],      32'hDEAD_BEEF);
      drain();

      // Reset during WAIT drops the fetch; memory survives.
      req_valid = 1'b1; req_pc = 32'h4;
      tick();
      set_idle();
      rst = 1'b1;
      tick();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_wait_valid%0d", d), 32'(resp_valid_o[d]), 32'd0);
         chk($sformatf("rst_wait_busy%0d", d),  32'(busy_o[d]),       32'd0);
      end
      set_idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_no_resp", 32'(resp_valid_o[0]), 32'd0);
      end
      req_valid = 1'b1; req_pc = 32'h0;
      tick();
      set_idle();
      tick();
      chk("rst_mem_kept_valid", 32'(resp_valid_o[0]), 32'd1);
      chk("rst_mem_kept_instr", resp_instr_o[0],      32'hDEAD_BEEF);
      drain();

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 49) == 0);
         req_valid  = ($urandom_range(0, 9) < 6);
         resp_ready = ($urandom_range(0, 9) < 7);
         load_en    = ($urandom_range(0, 9) < 2);
         load_addr  = 8'($urandom_range(0, 7));
         load_data  = $urandom();
         case ($urandom_range(0, 5))
            0, 1, 2: req_pc = 32'($urandom_range(0, 7)) << 2;
            3:       req_pc = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(1, 3));
            4:       req_pc = 32'h400 + (32'($urandom_range(0, 15)) << 2);
            default: req_pc = $urandom();
         endcase
         tick();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
